// File: rtl/readout_pkg.sv
// Shared types and width helpers for the readout arbiter.
// READOUT_PARITY_EN appends an even-parity bit to each frame.
package readout_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    GAP
  } state_t;

`ifdef READOUT_PARITY_EN
  localparam int PARITY_W = 1;
`else
  localparam int PARITY_W = 0;
`endif

  function automatic int ch_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int frame_width(
    input int ch_w,
    input int data_w
  );
    return ch_w + data_w + PARITY_W;
  endfunction

endpackage

// File: rtl/readout_arbiter_rr.sv
// Combinational round-robin pick: first requester at or after ptr.
// Module rr_arbiter; the pointer register lives in the parent.
module rr_arbiter
  import readout_pkg::*;
#(
  parameter int N_CH = 8,
  parameter int CH_W = ch_width(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  output logic [N_CH-1:0] gnt,
  output logic [CH_W-1:0] gnt_idx,
  output logic            gnt_vld
);

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      int k;
      logic [CH_W-1:0] kx;
      k = int'(ptr) + i;
      if (k >= N_CH) k = k - N_CH;
      kx = CH_W'(k);
      if (!gnt_vld && req[kx]) begin
        gnt_vld  = 1'b1;
        gnt[kx]  = 1'b1;
        gnt_idx  = kx;
      end
    end
  end

endmodule

// File: rtl/readout_arbiter.sv
// Round-robin readout scheduler: grant, ack, load, serialise a tagged frame.
// Define READOUT_PARITY_EN to append an even-parity bit to every frame.
module readout_arbiter
  import readout_pkg::*;
#(
  parameter int N_CH   = 8,
  parameter int DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic                   enable,
  input  logic [N_CH-1:0]        req,
  input  logic [N_CH*DATA_W-1:0] data,
  output logic [N_CH-1:0]        ack,
  output logic                   sout,
  output logic                   sframe,
  output logic                   busy
);

  localparam int CH_W    = ch_width(N_CH);
  localparam int FRAME_W = frame_width(CH_W, DATA_W);
  localparam int CNT_W   = ch_width(FRAME_W);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CH - 1);

  state_t             state_q, state_d;
  logic [CH_W-1:0]    ptr_q, ptr_d;
  logic [CH_W-1:0]    gidx_q, gidx_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [N_CH-1:0]    gnt;
  logic [CH_W-1:0]    gnt_idx;
  logic               gnt_vld;
  logic [DATA_W-1:0]  word;
  logic [FRAME_W-1:0] frame;

  rr_arbiter #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_rr (
    .req     (req),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign word = data[int'(gidx_q)*DATA_W +: DATA_W];

`ifdef READOUT_PARITY_EN
  assign frame = {gidx_q, word, ^{gidx_q, word}};
`else
  assign frame = {gidx_q, word};
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (enable && gnt_vld) begin
          state_d = LOAD;
          gidx_d  = gnt_idx;
          ptr_d   = (gnt_idx == CH_LAST) ? '0 : gnt_idx + 1'b1;
        end
      end
      LOAD: begin
        shreg_d = frame;
        cnt_d   = CNT_LAST;
        state_d = SHIFT;
      end
      SHIFT: begin
        shreg_d = shreg_q << 1;
        if (cnt_q == '0) begin
          state_d = GAP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered from next-state so they line up with the state.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      shreg_q <= '0;
      cnt_q   <= '0;
      ack     <= '0;
      sout    <= 1'b0;
      sframe  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      ack     <= (state_q == IDLE && state_d == LOAD) ? gnt : '0;
      sout    <= (state_d == SHIFT) & shreg_d[FRAME_W-1];
      sframe  <= (state_d == SHIFT);
      busy    <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_readout_arbiter.sv
// Scoreboard bench for readout_arbiter (N_CH=4, DATA_W=8).
// Honours READOUT_PARITY_EN when defined for the build.
module tb_readout_arbiter;

  localparam int N_CH   = 4;
  localparam int DATA_W = 8;
  localparam int CH_W   = 2;
`ifdef READOUT_PARITY_EN
  localparam int FRAME_W = CH_W + DATA_W + 1;
`else
  localparam int FRAME_W = CH_W + DATA_W;
`endif
  localparam int PERIOD = FRAME_W + 3;

  logic                   clk = 1'b0;
  logic                   rstb = 1'b0;
  logic                   enable = 1'b0;
  logic [N_CH-1:0]        req = '0;
  logic [N_CH*DATA_W-1:0] data = '0;
  logic [N_CH-1:0]        ack;
  logic                   sout;
  logic                   sframe;
  logic                   busy;

  readout_arbiter #(
    .N_CH   (N_CH),
    .DATA_W (DATA_W)
  ) dut (
    .clk    (clk),
    .rstb   (rstb),
    .enable (enable),
    .req    (req),
    .data   (data),
    .ack    (ack),
    .sout   (sout),
    .sframe (sframe),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                 ch;
    logic [FRAME_W-1:0] word;
  } exp_t;

  exp_t exp_q[$];
  int   start_cyc[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic check(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] want
  );
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  function automatic logic [FRAME_W-1:0] mk(
    input logic [1:0] ch,
    input logic [7:0] d
  );
`ifdef READOUT_PARITY_EN
    return {ch, d, ^{ch, d}};
`else
    return {ch, d};
`endif
  endfunction

  function automatic int oh2i(input logic [N_CH-1:0] v);
    for (int i = 0; i < N_CH; i++)
      if (v[i]) return i;
    return -1;
  endfunction

  task automatic expect_frame(
    input int         ch,
    input logic [7:0] d
  );
    exp_t e;
    e.ch   = ch;
    e.word = mk(2'(ch), d);
    exp_q.push_back(e);
  endtask

  // Monitor: rebuilds each frame from sout and pops the scoreboard.
  int                 ack_ch = -1;
  logic [FRAME_W-1:0] sh = '0;
  int                 nb = 0;

  initial forever begin
    @(negedge clk);
    if (!rstb) begin
      nb = 0;
    end else begin
      if (ack != '0) begin
        check("ack_onehot", 32'($countones(ack)), 32'd1);
        ack_ch = oh2i(ack);
      end
      if (sframe) begin
        if (nb == 0) start_cyc.push_back(cyc);
        sh = {sh[FRAME_W-2:0], sout};
        nb++;
      end else if (nb != 0) begin
        exp_t e;
        check("frame_len", 32'(nb), 32'(FRAME_W));
        check("gap_sout", 32'(sout), 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("frame_ch", 32'(ack_ch), 32'(e.ch));
          check("frame_word", 32'(sh), 32'(e.word));
        end
        nb = 0;
      end
    end
  end

  task automatic wait_ack(
    input  logic [N_CH-1:0] want,
    input  string           name,
    output int              n
  );
    n = 0;
    while (ack == '0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (ack == '0) begin
      check({name, "_timeout"}, 32'd0, 32'(want));
    end else begin
      check(name, 32'(ack), 32'(want));
      req = req & ~ack;
    end
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int n;
    int cnt;

    // Reset held with all channels requesting
    enable = 1'b1;
    req    = 4'b1111;
    data   = {8'h44, 8'h33, 8'h22, 8'h11};
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_sout", 32'(sout), 32'd0);
    check("rst_sframe", 32'(sframe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    expect_frame(0, 8'h11);
    rstb = 1'b1;
    wait_ack(4'b0001, "first_grant", n);
    req = '0;
    wait_idle();

    // Single request, latency and bit order
    data[2*8 +: 8] = 8'hA5;
    expect_frame(2, 8'hA5);
    req = 4'b0100;
    wait_ack(4'b0100, "single_ack", n);
    check("grant_lat", 32'(n), 32'd1);
    check("first_bit_sframe", 32'(sframe), 32'd1);
    check("first_bit_sout", 32'(sout), 32'd1);
    check("busy_mid", 32'(busy), 32'd1);
    wait_idle();

    // Contention wrap from ptr=3
    data[3*8 +: 8] = 8'h3C;
    data[0*8 +: 8] = 8'hC3;
    expect_frame(3, 8'h3C);
    expect_frame(0, 8'hC3);
    req = 4'b1001;
    wait_ack(4'b1000, "wrap_first", n);
    wait_ack(4'b0001, "wrap_second", n);
    wait_idle();

    // Reset pulse in frame bit 4
    data[2*8 +: 8] = 8'h5A;
    req = 4'b0100;
    wait_ack(4'b0100, "abort_ack", n);
    repeat (4) @(negedge clk);
    check("pre_rst_sframe", 32'(sframe), 32'd1);
    rstb = 1'b0;
    #1;
    check("async_sframe", 32'(sframe), 32'd0);
    check("async_sout", 32'(sout), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);

    // Fairness: ptr back at 0, grants 0,1,2,3,0
    data = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int k = 0; k < 5; k++)
      expect_frame(k % 4, 8'h11 * 8'((k % 4) + 1));
    start_cyc.delete();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      logic [N_CH-1:0] w;
      w = 4'b0001 << (k % 4);
      wait_ack(w, "rr_order", n);
      if (k < 4) req = req | w;
      else req = '0;
    end
    wait_idle();
    check("rr_frames", 32'(start_cyc.size()), 32'd5);
    for (int k = 1; k < 5; k++)
      if (k < start_cyc.size())
        check("rr_period", 32'(start_cyc[k] - start_cyc[k-1]),
              32'(PERIOD));

    // Enable dropped in frame bit 4 (ch1 data 03)
    data[1*8 +: 8] = 8'h03;
    expect_frame(1, 8'h03);
    expect_frame(3, 8'h44);
    req = 4'b0010;
    wait_ack(4'b0010, "en_ack", n);
    req = 4'b1000;
    repeat (4) @(negedge clk);
    enable = 1'b0;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ack != '0) cnt++;
    end
    check("no_grant_disabled", 32'(cnt), 32'd0);
    check("idle_disabled", 32'(busy), 32'd0);
    enable = 1'b1;
    wait_ack(4'b1000, "reenable_ack", n);
    wait_idle();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
